// File: rtl/glb_ld_addr_gen_pkg.sv
// Shared GLB load-path parameters, FSM state encoding and the shadowed transfer configuration.
// Latency: n/a (types, constants and one combinational helper only).
// Backpressure: n/a.
package glb_ld_addr_gen_pkg;

    localparam int LOOP_LEVEL          = 4;
    localparam int GLB_ADDR_WIDTH      = 22;
    localparam int MAX_NUM_WORDS_WIDTH = 21;
    localparam int MAX_STRIDE_WIDTH    = 11;
    localparam int QUEUE_DEPTH         = 4;
    localparam int BANK_BYTE_OFFSET    = 3;   // 64-bit bank word = 8 bytes
    localparam int CGRA_BYTE_OFFSET    = 1;   // 16-bit CGRA word = 2 bytes

    localparam int BANK_DATA_WIDTH  = 8 << BANK_BYTE_OFFSET;
    localparam int CGRA_DATA_WIDTH  = 8 << CGRA_BYTE_OFFSET;
    localparam int WORD_SEL_WIDTH   = BANK_BYTE_OFFSET - CGRA_BYTE_OFFSET;
    localparam int WORDS_PER_BANK   = 1 << WORD_SEL_WIDTH;
    localparam int DIM_WIDTH        = 3;
    localparam int CREDIT_WIDTH     = $clog2(QUEUE_DEPTH + 1);

    typedef enum logic [1:0] {
        LD_IDLE  = 2'd0,
        LD_ISSUE = 2'd1,
        LD_DRAIN = 2'd2,
        LD_DONE  = 2'd3
    } ld_state_t;

    typedef struct packed {
        logic [GLB_ADDR_WIDTH-1:0]                             start_addr;
        logic [DIM_WIDTH-1:0]                                  num_dim;
        logic [LOOP_LEVEL-1:0][MAX_NUM_WORDS_WIDTH-1:0]        dim_range;
        logic [LOOP_LEVEL-1:0][MAX_STRIDE_WIDTH-1:0]           stride;
    } ld_cfg_t;

    // A transfer with no active dims, or with any active dim of zero
    // iterations, produces no words at all.
    function automatic logic ld_cfg_is_empty(input ld_cfg_t cfg);
        logic empty;
        empty = (cfg.num_dim == '0);
        for (int d = 0; d < LOOP_LEVEL; d++) begin
            if ((DIM_WIDTH'(d) < cfg.num_dim) && (cfg.dim_range[d] == '0)) begin
                empty = 1'b1;
            end
        end
        return empty;
    endfunction

endpackage

// File: rtl/glb_ld_addr_gen_if.sv
// Bank read request/response channel plus the CGRA-facing word stream of the GLB load path.
// Latency: n/a (signal bundle). master = address generator, slave = arbiter/bank/CGRA side.
// Backpressure: rd_req_ready stalls requests; responses and the CGRA stream have no backpressure.
interface glb_ld_addr_gen_if;
    import glb_ld_addr_gen_pkg::*;

    logic                       rd_req_valid;
    logic [GLB_ADDR_WIDTH-1:0]  rd_req_addr;
    logic                       rd_req_ready;
    logic                       rd_rsp_valid;
    logic [BANK_DATA_WIDTH-1:0] rd_rsp_data;
    logic [CGRA_DATA_WIDTH-1:0] data_g2f;
    logic                       data_valid_g2f;

    modport master (
        output rd_req_valid,
        output rd_req_addr,
        input  rd_req_ready,
        input  rd_rsp_valid,
        input  rd_rsp_data,
        output data_g2f,
        output data_valid_g2f
    );

    modport slave (
        input  rd_req_valid,
        input  rd_req_addr,
        output rd_req_ready,
        output rd_rsp_valid,
        output rd_rsp_data,
        input  data_g2f,
        input  data_valid_g2f
    );

endinterface

// File: rtl/glb_ld_offset_fifo.sv
// Small synchronous FIFO remembering the CGRA-word offset of each outstanding bank read.
// Latency: pop_dat shows the head entry combinationally; a push is visible one cycle later.
// Backpressure: push ignored when full, pop ignored when empty.
// Ports: clk/reset, push/push_dat, pop/pop_dat, full, empty.
module glb_ld_offset_fifo
    import glb_ld_addr_gen_pkg::*;
#(
    parameter int WIDTH = WORD_SEL_WIDTH,
    parameter int DEPTH = QUEUE_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Storage needs no reset: an entry is only ever read after being written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

endmodule

// File: rtl/glb_ld_addr_gen.sv
// GLB load address generator: walks a nested loop issuing bank reads, unpacks each bank word to one CGRA word.
// Latency: first request the cycle after start; data_g2f one cycle after the matching rd_rsp_valid.
// Backpressure: request held while rd_req_ready=0; stall or zero credits (QUEUE_DEPTH outstanding) drop valid.
// Ports: clk/reset; cfg_* shadowed at start_pulse; stall; busy/done_pulse status; ld_if = request, response and CGRA stream.
module glb_ld_addr_gen
    import glb_ld_addr_gen_pkg::*;
(
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [GLB_ADDR_WIDTH-1:0]                 cfg_start_addr,
    input  logic [DIM_WIDTH-1:0]                      cfg_num_dim,
    input  logic [LOOP_LEVEL*MAX_NUM_WORDS_WIDTH-1:0] cfg_range,
    input  logic [LOOP_LEVEL*MAX_STRIDE_WIDTH-1:0]    cfg_stride,
    input  logic                                      start_pulse,
    input  logic                                      stall,
    output logic                                      busy,
    output logic                                      done_pulse,
    glb_ld_addr_gen_if.master                         ld_if
);
    // Offsets count CGRA words; one bit fewer than the byte address suffices
    // since the sum is shifted left by one and wraps modulo the address space.
    localparam int OFF_W = GLB_ADDR_WIDTH - CGRA_BYTE_OFFSET;

    ld_state_t state;
    ld_state_t state_nxt;
    ld_cfg_t   cfg_in;
    ld_cfg_t   cfg_q;

    logic [MAX_NUM_WORDS_WIDTH-1:0] idx     [LOOP_LEVEL];
    logic [MAX_NUM_WORDS_WIDTH-1:0] idx_nxt [LOOP_LEVEL];
    logic [OFF_W-1:0]               off     [LOOP_LEVEL];
    logic [OFF_W-1:0]               off_nxt [LOOP_LEVEL];
    logic [OFF_W-1:0]               off_sum;
    logic                           last_req;

    logic [CREDIT_WIDTH-1:0]        credits;
    logic                           start_accept;
    logic                           fire;
    logic                           rsp_pop;
    logic                           fifo_full;
    logic                           fifo_empty;
    logic [WORD_SEL_WIDTH-1:0]      rsp_word_sel;
    logic [WORDS_PER_BANK-1:0][CGRA_DATA_WIDTH-1:0] rsp_words;

    // Byte address bit 0 is meaningless for 16-bit words; num_dim beyond the
    // implemented depth behaves as the full depth.
    assign cfg_in.start_addr = {cfg_start_addr[GLB_ADDR_WIDTH-1:1], 1'b0};
    assign cfg_in.num_dim    = (cfg_num_dim > DIM_WIDTH'(LOOP_LEVEL)) ?
                               DIM_WIDTH'(LOOP_LEVEL) : cfg_num_dim;
    assign cfg_in.dim_range  = cfg_range;
    assign cfg_in.stride     = cfg_stride;

    assign start_accept = (state == LD_IDLE) && start_pulse;
    assign fire         = ld_if.rd_req_valid && ld_if.rd_req_ready;
    assign rsp_pop      = ld_if.rd_rsp_valid && !fifo_empty;
    assign rsp_words    = ld_if.rd_rsp_data;

    // Odometer step: dim0 advances; a dim at its last iteration wraps to zero
    // and carries into the next active dim. last_req marks the final point.
    always_comb begin
        logic carry;
        carry    = 1'b1;
        last_req = 1'b1;
        for (int d = 0; d < LOOP_LEVEL; d++) begin
            idx_nxt[d] = idx[d];
            off_nxt[d] = off[d];
            if (DIM_WIDTH'(d) < cfg_q.num_dim) begin
                if (idx[d] != (cfg_q.dim_range[d] - MAX_NUM_WORDS_WIDTH'(1))) begin
                    last_req = 1'b0;
                    if (carry) begin
                        idx_nxt[d] = idx[d] + MAX_NUM_WORDS_WIDTH'(1);
                        off_nxt[d] = off[d] + OFF_W'(cfg_q.stride[d]);
                        carry      = 1'b0;
                    end
                end else if (carry) begin
                    idx_nxt[d] = '0;
                    off_nxt[d] = '0;
                end
            end
        end
    end

    always_comb begin
        off_sum = '0;
        for (int d = 0; d < LOOP_LEVEL; d++) begin
            off_sum = off_sum + off[d];
        end
    end

    assign ld_if.rd_req_addr = cfg_q.start_addr + {off_sum, 1'b0};

    // Next state and state-decoded outputs. Credits and FIFO occupancy move
    // together, so the full term never changes the result; it guards the push.
    always_comb begin
        state_nxt          = state;
        busy               = 1'b0;
        done_pulse         = 1'b0;
        ld_if.rd_req_valid = 1'b0;
        case (state)
            LD_IDLE: begin
                if (start_pulse) begin
                    state_nxt = ld_cfg_is_empty(cfg_in) ? LD_DONE : LD_ISSUE;
                end
            end
            LD_ISSUE: begin
                busy               = 1'b1;
                ld_if.rd_req_valid = !stall && (credits != '0) && !fifo_full;
                if (fire && last_req) begin
                    state_nxt = LD_DRAIN;
                end
            end
            LD_DRAIN: begin
                busy = 1'b1;
                if (fifo_empty) begin
                    state_nxt = LD_DONE;
                end
            end
            LD_DONE: begin
                busy       = 1'b1;
                done_pulse = 1'b1;
                state_nxt  = LD_IDLE;
            end
            default: begin
                state_nxt = LD_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state                <= LD_IDLE;
            cfg_q                <= '0;
            credits              <= CREDIT_WIDTH'(QUEUE_DEPTH);
            ld_if.data_g2f       <= '0;
            ld_if.data_valid_g2f <= 1'b0;
            for (int d = 0; d < LOOP_LEVEL; d++) begin
                idx[d] <= '0;
                off[d] <= '0;
            end
        end else begin
            state <= state_nxt;

            if (start_accept) begin
                cfg_q <= cfg_in;
                for (int d = 0; d < LOOP_LEVEL; d++) begin
                    idx[d] <= '0;
                    off[d] <= '0;
                end
            end else if (fire) begin
                for (int d = 0; d < LOOP_LEVEL; d++) begin
                    idx[d] <= idx_nxt[d];
                    off[d] <= off_nxt[d];
                end
            end

            if (fire && !rsp_pop) begin
                credits <= credits - CREDIT_WIDTH'(1);
            end else if (rsp_pop && !fire) begin
                credits <= credits + CREDIT_WIDTH'(1);
            end

            // A response with nothing outstanding (e.g. left over from before
            // a reset) is dropped here and never reaches the CGRA.
            ld_if.data_valid_g2f <= rsp_pop;
            if (rsp_pop) begin
                ld_if.data_g2f <= rsp_words[rsp_word_sel];
            end
        end
    end

    glb_ld_offset_fifo #(
        .WIDTH (WORD_SEL_WIDTH),
        .DEPTH (QUEUE_DEPTH)
    ) u_offset_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fire),
        .push_dat (ld_if.rd_req_addr[BANK_BYTE_OFFSET-1:CGRA_BYTE_OFFSET]),
        .pop      (rsp_pop),
        .pop_dat  (rsp_word_sel),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

endmodule

// File: tb/tb_glb_ld_addr_gen.sv
// Testbench for glb_ld_addr_gen: directed transfers, an arbiter/bank responder and an address/data scoreboard.
// Latency: n/a. Backpressure: responder can randomise rd_req_ready and withhold responses.
module tb_glb_ld_addr_gen;
    import glb_ld_addr_gen_pkg::*;

    logic        clk = 1'b1;
    logic        reset;
    logic [21:0] cfg_start_addr;
    logic [2:0]  cfg_num_dim;
    logic [83:0] cfg_range;
    logic [43:0] cfg_stride;
    logic        start_pulse;
    logic        stall;
    logic        busy;
    logic        done_pulse;

    glb_ld_addr_gen_if ld_if ();

    glb_ld_addr_gen dut (
        .clk            (clk),
        .reset          (reset),
        .cfg_start_addr (cfg_start_addr),
        .cfg_num_dim    (cfg_num_dim),
        .cfg_range      (cfg_range),
        .cfg_stride     (cfg_stride),
        .start_pulse    (start_pulse),
        .stall          (stall),
        .busy           (busy),
        .done_pulse     (done_pulse),
        .ld_if          (ld_if)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          fire_cnt = 0;
    logic [21:0] exp_addr [$];
    logic [15:0] exp_data [$];
    logic [63:0] pending  [$];
    bit          rsp_en = 1'b1;
    bit          rand_ready = 1'b0;
    bit          stray_rsp = 1'b0;
    bit          override_first = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Bank contents as seen by the responder: each lane encodes its own bank address and lane number.
    function automatic logic [63:0] bank_word(input logic [21:0] a);
        logic [63:0] w;
        logic [1:0]  j2;
        w = '0;
        for (int j = 0; j < 4; j++) begin
            j2 = 2'(j);
            w[16*j +: 16] = {a[15:3], j2, 1'b1};
        end
        return w;
    endfunction

    // Arbiter/bank model and scoreboard, sampling away from the active edge.
    always @(negedge clk) begin : responder
        logic [21:0] a;
        logic [63:0] w;
        if (reset) begin
            ld_if.rd_rsp_valid = 1'b0;
            ld_if.rd_rsp_data  = '0;
            ld_if.rd_req_ready = 1'b1;
        end else begin
            if (ld_if.data_valid_g2f) begin
                check("output_expected", 64'(exp_data.size() == 0), 0);
                if (exp_data.size() != 0) begin
                    check("data_g2f", ld_if.data_g2f, exp_data.pop_front());
                end
            end
            ld_if.rd_rsp_valid = 1'b0;
            if (stray_rsp) begin
                ld_if.rd_rsp_valid = 1'b1;
                ld_if.rd_rsp_data  = 64'hFFFF_EEEE_1234_5678;
                stray_rsp = 1'b0;
            end else if (rsp_en && pending.size() != 0) begin
                ld_if.rd_rsp_valid = 1'b1;
                ld_if.rd_rsp_data  = pending.pop_front();
                if (override_first) begin
                    ld_if.rd_rsp_data = 64'hDDDD_CCCC_BBBB_AAAA;
                    override_first = 1'b0;
                end
            end
            ld_if.rd_req_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (ld_if.rd_req_valid && ld_if.rd_req_ready) begin
                fire_cnt++;
                pending.push_back(bank_word(ld_if.rd_req_addr));
                check("request_expected", 64'(exp_addr.size() == 0), 0);
                if (exp_addr.size() != 0) begin
                    a = exp_addr.pop_front();
                    check("rd_req_addr", ld_if.rd_req_addr, a);
                    w = bank_word(a);
                    exp_data.push_back(w[16*a[2:1] +: 16]);
                end
            end
        end
    end

    task automatic start_xfer(input logic [21:0] sa, input logic [2:0] nd,
                              input logic [20:0] r0, r1, r2, r3,
                              input logic [10:0] s0, s1, s2, s3);
        cfg_start_addr = sa;
        cfg_num_dim    = nd;
        cfg_range      = {r3, r2, r1, r0};
        cfg_stride     = {s3, s2, s1, s0};
        start_pulse    = 1'b1;
        @(posedge clk); #1;
        start_pulse    = 1'b0;
    endtask

    // Reference nested loop: dim0 innermost, inactive dims contribute one pass.
    task automatic model_push(input logic [21:0] sa, input int nd,
                              input int r0, r1, r2, r3, input int s0, s1, s2, s3);
        int r [4];
        int s [4];
        r = '{r0, r1, r2, r3};
        s = '{s0, s1, s2, s3};
        for (int k = 0; k < 4; k++) begin
            if (k >= nd) r[k] = 1;
        end
        for (int i3 = 0; i3 < r[3]; i3++)
            for (int i2 = 0; i2 < r[2]; i2++)
                for (int i1 = 0; i1 < r[1]; i1++)
                    for (int i0 = 0; i0 < r[0]; i0++)
                        exp_addr.push_back(22'(32'(sa) + 2 * (i0*s[0] + i1*s[1] + i2*s[2] + i3*s[3])));
    endtask

    task automatic wait_done(input string tag, input int budget, output int cyc);
        cyc = 1;
        while (done_pulse !== 1'b1 && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_done_pulse"}, 64'(done_pulse), 1);
        check({tag, "_busy_in_done"}, 64'(busy), 1);
        check({tag, "_addrs_left"}, exp_addr.size(), 0);
        check({tag, "_words_left"}, exp_data.size(), 0);
        @(posedge clk); #1;
        check({tag, "_idle_after"}, {62'd0, busy, done_pulse}, 0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not reach its end within the time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int base;
        int cyc;
        reset = 1'b1; start_pulse = 1'b0; stall = 1'b0;
        cfg_start_addr = '0; cfg_num_dim = '0; cfg_range = '0; cfg_stride = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_valid", 64'(ld_if.rd_req_valid), 0);
        check("rst_req_addr", ld_if.rd_req_addr, 0);
        check("rst_data_valid", 64'(ld_if.data_valid_g2f), 0);
        check("rst_data", ld_if.data_g2f, 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_done", 64'(done_pulse), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // 1: single dim, four consecutive words
        base = fire_cnt;
        exp_addr = '{22'h100, 22'h102, 22'h104, 22'h106};
        start_xfer(22'h100, 3'd1, 21'd4, 21'd0, 21'd0, 21'd0, 11'd1, 11'd0, 11'd0, 11'd0);
        wait_done("t1", 100, cyc);
        check("t1_req_count", fire_cnt - base, 4);

        // 2: two dims; a second start with new cfg mid-transfer is ignored
        base = fire_cnt;
        exp_addr = '{22'd0, 22'd2, 22'd4, 22'd16, 22'd18, 22'd20};
        start_xfer(22'h0, 3'd2, 21'd3, 21'd2, 21'd0, 21'd0, 11'd1, 11'd8, 11'd0, 11'd0);
        @(posedge clk); #1;
        cfg_start_addr = 22'h500; cfg_range = {21'd0, 21'd0, 21'd9, 21'd9};
        start_pulse = 1'b1;
        @(posedge clk); #1;
        start_pulse = 1'b0;
        wait_done("t2", 100, cyc);
        check("t2_req_count", fire_cnt - base, 6);

        // 3: responses withheld -> credit limit, then lane select check
        base = fire_cnt;
        rsp_en = 1'b0;
        model_push(22'h2, 1, 8, 0, 0, 0, 1, 0, 0, 0);
        start_xfer(22'h2, 3'd1, 21'd8, 21'd0, 21'd0, 21'd0, 11'd1, 11'd0, 11'd0, 11'd0);
        repeat (10) @(posedge clk);
        #1;
        check("t3_outstanding", fire_cnt - base, 4);
        check("t3_valid_blocked", 64'(ld_if.rd_req_valid), 0);
        exp_data[0] = 16'hBBBB;
        override_first = 1'b1;
        rsp_en = 1'b1;
        wait_done("t3", 100, cyc);
        check("t3_req_count", fire_cnt - base, 8);

        // 4: empty transfers
        base = fire_cnt;
        start_xfer(22'h0, 3'd2, 21'd5, 21'd0, 21'd0, 21'd0, 11'd1, 11'd1, 11'd0, 11'd0);
        wait_done("t4a", 10, cyc);
        check("t4a_done_latency_ok", 64'(cyc <= 2), 1);
        check("t4a_req_count", fire_cnt - base, 0);
        base = fire_cnt;
        start_xfer(22'h0, 3'd0, 21'd5, 21'd5, 21'd0, 21'd0, 11'd1, 11'd1, 11'd0, 11'd0);
        wait_done("t4b", 10, cyc);
        check("t4b_done_latency_ok", 64'(cyc <= 2), 1);
        check("t4b_req_count", fire_cnt - base, 0);

        // 5: address wrap at the top of the space
        exp_addr = '{22'h3FFFFE, 22'h000000};
        start_xfer(22'h3FFFFE, 3'd1, 21'd2, 21'd0, 21'd0, 21'd0, 11'd1, 11'd0, 11'd0, 11'd0);
        wait_done("t5", 50, cyc);

        // 6: reset mid-transfer, stray response, clean restart with stall
        base = fire_cnt;
        model_push(22'h40, 1, 16, 0, 0, 0, 1, 0, 0, 0);
        start_xfer(22'h40, 3'd1, 21'd16, 21'd0, 21'd0, 21'd0, 11'd1, 11'd0, 11'd0, 11'd0);
        cyc = 0;
        while (fire_cnt - base < 3 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("t6_three_fires", 64'(fire_cnt - base >= 3), 1);
        reset = 1'b1;
        exp_addr.delete(); exp_data.delete(); pending.delete();
        @(posedge clk); #1;
        check("t6_rst_req_valid", 64'(ld_if.rd_req_valid), 0);
        check("t6_rst_req_addr", ld_if.rd_req_addr, 0);
        check("t6_rst_data_valid", 64'(ld_if.data_valid_g2f), 0);
        check("t6_rst_busy", 64'(busy), 0);
        reset = 1'b0;
        stray_rsp = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("t6_stray_no_output", 64'(ld_if.data_valid_g2f), 0);
        end

        base = fire_cnt;
        rand_ready = 1'b1;
        model_push(22'h200, 4, 2, 3, 2, 2, 1, 2, 16, 100);
        start_xfer(22'h200, 3'd4, 21'd2, 21'd3, 21'd2, 21'd2, 11'd1, 11'd2, 11'd16, 11'd100);
        cyc = 0;
        while (fire_cnt - base < 5 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("t6_pre_stall_fires", 64'(fire_cnt - base >= 5), 1);
        stall = 1'b1;
        base = fire_cnt;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t6_stall_valid_low", 64'(ld_if.rd_req_valid), 0);
            @(posedge clk); #1;
        end
        check("t6_stall_no_fires", fire_cnt - base, 0);
        stall = 1'b0;
        wait_done("t6", 400, cyc);
        rand_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
